regfile_dump_ctrl: RTL and testbench
====================================

Name: regfile_dump_ctrl

Overview:
Read-side sequencer for the 32x64 register file: on a start pulse it walks a register address range through both read ports (A and B), reading two registers per cycle. It buffers the returned data and streams it out one 64-bit word per cycle over a valid/ready interface, with a running XOR checksum. It sits between the register file read ports and a debug/trace sink, used for state dump and post-reset register checks.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (highest address NUM_REGS-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
start  input  1  begin dump; sampled only when busy=0
first_addr  input  ADDR_W  first register to dump; captured with start
last_addr  input  ADDR_W  last register to dump, inclusive; captured with start
rdAddrA  output  ADDR_W  register file read address A
rdDataA  input  DATA_W  register file read data A (combinational from rdAddrA)
rdAddrB  output  ADDR_W  register file read address B
rdDataB  input  DATA_W  register file read data B (combinational from rdAddrB)
out_valid  output  1  out_data/out_addr valid
out_ready  input  1  sink accepts word
out_data  output  DATA_W  register value
out_addr  output  ADDR_W  register index of out_data
out_last  output  1  asserted with final word of dump
busy  output  1  dump in progress
done  output  1  one-cycle pulse at end of dump
range_err  output  1  one-cycle pulse when first_addr > last_addr at start
checksum  output  DATA_W  XOR of all words accepted in current/last dump

Behaviour:
- Reset (reset=0 at posedge): state IDLE; every output 0 (rdAddrA, rdAddrB, out_valid, out_data, out_addr, out_last, busy, done, range_err, checksum); buffer emptied. Reset mid-dump aborts with no done pulse.
- Handshake: a word transfers on a cycle with out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_data/out_addr/out_last hold stable.
- States: IDLE, READ, EMIT, FINISH.
- IDLE: start=1 with first_addr<=last_addr -> latch range; set next_addr=first_addr; clear checksum; busy=1; go to READ. start=1 with first_addr>last_addr -> range_err pulse next cycle, no output, no done, stay IDLE. start while busy=1 is ignored.
- Read addressing: rdAddrA=next_addr, rdAddrB=next_addr+1 (ADDR_W-bit wrap). Slot B is valid only if next_addr<last_addr; no wrap from 31 to 0 ever produces a word.
- Buffer: 2 entries {data, addr}. Capture (refill) occurs when the buffer is empty, or holds 1 entry that transfers this cycle, and addresses remain. Capture loads A (and B if valid); next_addr advances by 2 (or 1 if B invalid).
- READ: first capture cycle; go to EMIT. Latency: start at posedge T -> rdAddrA=first_addr during cycle T+1 -> out_valid=1 in cycle T+2.
- EMIT: head entry drives outputs; refill per the rule above -> sustained throughput 1 word/cycle with out_ready held high.
- out_last=1 when the head entry addr==last_addr.
- checksum <= checksum XOR out_data on every transfer.
- FINISH: entered after the transfer with out_last=1; done=1 and busy=0 for exactly that one cycle; go to IDLE. checksum holds until next accepted start.
- rdAddrA/rdAddrB hold their last values when not capturing.
- Single-register dump (first=last): one word with out_last=1.

Decomposition:
- Shared package regfile_pkg: DATA_W, ADDR_W, NUM_REGS constants; state encoding localparams (IDLE=0, READ=1, EMIT=2, FINISH=3).
- One sub-module: dump_buf2, the 2-entry {data,addr} buffer with push-1/push-2/pop and count output; FSM and address counter stay in the top.

Test Plan:
- Full dump 0..31, regs preloaded reg[i]=i*0x0101010101010101, out_ready=1 -> 32 words in 32 consecutive cycles starting at T+2, out_last on addr 31, done pulse, checksum = XOR of all 32 values.
- Range 5..5 -> exactly one word addr 5, out_last=1, done one cycle after transfer, checksum=reg5.
- Range 30..31, out_ready toggled 1/0 each cycle -> data held stable while stalled, words 30 then 31, no addr 0 emitted.
- first_addr=9, last_addr=3 -> range_err pulse, out_valid stays 0, busy stays 0, no done.
- Reset (reset=0) asserted mid-dump after 4 transfers of 0..31 -> all outputs 0 next cycle, no done; new start 0..1 yields words 0,1 and fresh checksum.
- start reasserted while busy with different range -> ignored, original dump completes unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, FSM states and buffer entry type for the register dump path
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W = 64;
  localparam int ADDR_W = $clog2(NUM_REGS);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EMIT = 2'd2, FINISH = 2'd3} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;
endpackage

// File: rtl/dump_buf2.sv
// dump_buf2: two-entry {data,addr} FIFO with pop and push of zero, one or two entries per cycle
module dump_buf2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pop,
  input  logic [1:0] push,
  input  entry_t     in_a,
  input  entry_t     in_b,
  output entry_t     head,
  output logic [1:0] count
);
  entry_t e0, e1;
  logic [1:0] cnt_p;
  assign cnt_p = count - {1'b0, pop};
  assign head = e0;
  // pushes land behind whatever survives this cycle's pop
  always_ff @(posedge clk)
    if (!reset) begin
      count <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= cnt_p + push;
      e0 <= (push != 2'd0 && cnt_p == 2'd0) ? in_a : pop ? e1 : e0;
      e1 <= (push == 2'd2) ? in_b : (push != 2'd0 && cnt_p == 2'd1) ? in_a : e1;
    end
endmodule

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: walks a register range through two read ports and streams it out with a checksum
module regfile_dump_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rdAddrA,
  input  logic [DATA_W-1:0] rdDataA,
  output logic [ADDR_W-1:0] rdAddrB,
  input  logic [DATA_W-1:0] rdDataB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [DATA_W-1:0] checksum
);
  state_t state, state_n;
  logic [ADDR_W-1:0] next_addr, last_r, adv;
  logic rem, xfer, cap, b_ok, go, bad;
  logic [1:0] cnt, push;
  entry_t head;
  assign go = state == IDLE && start && first_addr <= last_addr;
  assign bad = state == IDLE && start && first_addr > last_addr;
  assign rdAddrA = next_addr;
  assign out_valid = cnt != 2'd0;
  assign xfer = out_valid && out_ready;
  assign b_ok = next_addr < last_r;
  // rem tracks "addresses left" explicitly so the 31->0 wrap can never look like more work
  assign cap = (state == READ || state == EMIT) && rem && (cnt == 2'd0 || (cnt == 2'd1 && xfer));
  assign push = cap ? (b_ok ? 2'd2 : 2'd1) : 2'd0;
  assign adv = next_addr + (b_ok ? ADDR_W'(2) : ADDR_W'(1));
  assign out_data = head.data;
  assign out_addr = head.addr;
  assign out_last = out_valid && head.addr == last_r;
  assign busy = state == READ || state == EMIT;
  assign done = state == FINISH;
  dump_buf2 u_buf (
    .clk  (clk),
    .reset(reset),
    .pop  (xfer),
    .push (push),
    .in_a ({rdDataA, next_addr}),
    .in_b ({rdDataB, rdAddrB}),
    .head (head),
    .count(cnt)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? READ : IDLE;
      READ:    state_n = EMIT;
      EMIT:    state_n = (xfer && out_last) ? FINISH : EMIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      next_addr <= '0;
      rdAddrB <= '0;
      last_r <= '0;
      rem <= 1'b0;
      range_err <= 1'b0;
      checksum <= '0;
    end else begin
      state <= state_n;
      range_err <= bad;
      if (go) begin
        next_addr <= first_addr;
        rdAddrB <= first_addr + ADDR_W'(1);
        last_r <= last_addr;
        rem <= 1'b1;
        checksum <= '0;
      end else begin
        if (cap) begin
          next_addr <= adv;
          rdAddrB <= adv + ADDR_W'(1);
          rem <= b_ok && (next_addr + ADDR_W'(1) != last_r);
        end
        if (xfer) checksum <= checksum ^ head.data;
      end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: randomized dumps checked against an in-order address/data/checksum model
module tb_regfile_dump_ctrl;
  logic clk = 0, reset = 0, start = 0, out_ready = 0;
  logic [4:0] first_addr = 0, last_addr = 0, rdAddrA, rdAddrB, out_addr;
  logic [63:0] rdDataA, rdDataB, out_data, checksum;
  logic out_valid, out_last, busy, done, range_err;
  logic [63:0] regs [32];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];
  regfile_dump_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done), .range_err(range_err), .checksum(checksum)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_addrA"}, rdAddrA, 0);
    check({tag, "_addrB"}, rdAddrB, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_oaddr"}, out_addr, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rerr"}, range_err, 0);
    check({tag, "_cksum"}, checksum, 0);
  endtask
  // mode: 0 ready high, 1 toggling, 2 random; poke re-starts while busy; abort_n resets after n words
  task automatic dump(input int f, input int l, input int mode, input bit poke, input int abort_n);
    logic [63:0] exp_ck = 0, pd = 0;
    logic [4:0] pa = 0;
    int idx = f, got = 0, cyc = 0;
    bit fin = 0, pstall = 0;
    @(negedge clk);
    start = 1; first_addr = 5'(f); last_addr = 5'(l);
    @(negedge clk);
    start = 0;
    check("busy_T1", busy, 1);
    check("rdAddrA_T1", rdAddrA, f);
    check("rdAddrB_T1", rdAddrB, (f + 1) % 32);
    check("valid_T1", out_valid, 0);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      start = 0;
      cyc++;
      if (abort_n >= 0 && got == abort_n) begin
        reset = 0; out_ready = 0;
        @(negedge clk);
        check_zero("abort");
        reset = 1;
        repeat (3) begin
          @(negedge clk);
          check("abort_nodone", done, 0);
          check("abort_idle", busy, 0);
        end
        fin = 1;
        continue;
      end
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
      if (poke && cyc == 3) begin
        start = 1; first_addr = 5'(l + 1); last_addr = 5'(31);
      end
      if (pstall) begin
        check("hold_data", out_data, pd);
        check("hold_addr", out_addr, pa);
      end
      check("valid", out_valid, 1);
      pstall = out_valid && !out_ready;
      pd = out_data; pa = out_addr;
      if (out_valid && out_ready) begin
        if (mode == 0) check("cycle", cyc, got + 1);
        check("addr", out_addr, idx);
        check("data", out_data, regs[idx]);
        check("last", out_last, idx == l);
        exp_ck ^= regs[idx];
        idx++; got++;
        if (idx > l) begin
          @(negedge clk);
          start = 0;
          check("done", done, 1);
          check("busy_fin", busy, 0);
          check("valid_fin", out_valid, 0);
          check("checksum", checksum, exp_ck);
          @(negedge clk);
          check("done_pulse", done, 0);
          check("checksum_hold", checksum, exp_ck);
          fin = 1;
        end
      end
    end
    if (!fin) check("timeout", 0, 1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'(i) * 64'h0101010101010101;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1;
    @(negedge clk);
    dump(0, 31, 0, 0, -1);
    dump(5, 5, 0, 0, -1);
    dump(30, 31, 1, 0, -1);
    @(negedge clk);
    start = 1; first_addr = 9; last_addr = 3;
    @(negedge clk);
    start = 0;
    check("range_err", range_err, 1);
    check("rerr_busy", busy, 0);
    check("rerr_valid", out_valid, 0);
    repeat (3) begin
      @(negedge clk);
      check("rerr_pulse", range_err, 0);
      check("rerr_nodone", done, 0);
      check("rerr_novalid", out_valid, 0);
    end
    dump(0, 31, 0, 0, 4);
    dump(0, 1, 0, 0, -1);
    dump(10, 20, 0, 1, -1);
    for (int k = 0; k < 8; k++) begin
      int a, b;
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      a = $urandom_range(0, 31);
      b = $urandom_range(a, 31);
      dump(a, b, 2, k % 2 == 1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
